// File: rtl/semafor_pkg.sv
// Phase codes shared by the sequencer, the display-selection stage and the stimuli bench.
package semafor_pkg;

    typedef enum logic [2:0] {
        ST_CAR_GREEN   = 3'd0,
        ST_CAR_YELLOW  = 3'd1,
        ST_ALL_RED_1   = 3'd2,
        ST_PED_GREEN   = 3'd3,
        ST_PED_BLINK   = 3'd4,
        ST_ALL_RED_2   = 3'd5,
        ST_MAINT_BLINK = 3'd6,
        ST_UNUSED      = 3'd7
    } phase_t;

    // Successor in the normal pedestrian cycle; anything unexpected parks in ALL_RED_2.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            ST_CAR_GREEN:  next_phase = ST_CAR_YELLOW;
            ST_CAR_YELLOW: next_phase = ST_ALL_RED_1;
            ST_ALL_RED_1:  next_phase = ST_PED_GREEN;
            ST_PED_GREEN:  next_phase = ST_PED_BLINK;
            ST_PED_BLINK:  next_phase = ST_ALL_RED_2;
            ST_ALL_RED_2:  next_phase = ST_CAR_GREEN;
            default:       next_phase = ST_ALL_RED_2;
        endcase
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Free-running divider producing a one-cycle tick every CLK_HZ clocks.
module sec_prescaler #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/semafor_ctrl.sv
// Pedestrian-crossing phase sequencer with request latching, maintenance flashing and a seconds countdown.
module semafor_ctrl
    import semafor_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned T_GREEN     = 20,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALLRED    = 2,
    parameter int unsigned T_PED       = 10,
    parameter int unsigned T_PEDBLINK  = 4,
    parameter int unsigned SHORT_GREEN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ped_req,
    input  logic       maint,
    output logic [2:0] stare_semafor,
    output logic [7:0] countdown,
    output logic       blink,
    output logic       ped_ack
);

    localparam logic [7:0] TG_C = 8'(T_GREEN);
    localparam logic [7:0] TY_C = 8'(T_YELLOW);
    localparam logic [7:0] TA_C = 8'(T_ALLRED);
    localparam logic [7:0] TP_C = 8'(T_PED);
    localparam logic [7:0] TB_C = 8'(T_PEDBLINK);
    localparam logic [7:0] SG_C = 8'(SHORT_GREEN);

    phase_t     state, state_nx;
    logic [7:0] cd, cd_nx;
    logic       blink_r, blink_nx;
    logic       ack, ack_nx;
    logic       ped_s1, ped_s2, ped_prev;
    logic       maint_s1, maint_s2;
    logic       tick;
    logic       ped_edge;

    function automatic logic [7:0] phase_ticks(input phase_t p);
        case (p)
            ST_CAR_GREEN:  phase_ticks = TG_C;
            ST_CAR_YELLOW: phase_ticks = TY_C;
            ST_ALL_RED_1:  phase_ticks = TA_C;
            ST_PED_GREEN:  phase_ticks = TP_C;
            ST_PED_BLINK:  phase_ticks = TB_C;
            ST_ALL_RED_2:  phase_ticks = TA_C;
            default:       phase_ticks = 8'd0;
        endcase
    endfunction

    sec_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign ped_edge      = ped_s2 & ~ped_prev;
    assign stare_semafor = state;
    assign countdown     = cd;
    assign blink         = blink_r;
    assign ped_ack       = ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_ALL_RED_2;
            cd       <= TA_C;
            blink_r  <= 1'b0;
            ack      <= 1'b0;
            ped_s1   <= 1'b0;
            ped_s2   <= 1'b0;
            ped_prev <= 1'b0;
            maint_s1 <= 1'b0;
            maint_s2 <= 1'b0;
        end else begin
            state    <= state_nx;
            cd       <= cd_nx;
            blink_r  <= blink_nx;
            ack      <= ack_nx;
            ped_s1   <= ped_req;
            ped_s2   <= ped_s1;
            ped_prev <= ped_s2;
            maint_s1 <= maint;
            maint_s2 <= maint_s1;
        end
    end

    always_comb begin
        state_nx = state;
        cd_nx    = cd;
        blink_nx = blink_r;
        ack_nx   = ack;

        if (ped_edge && state != ST_PED_GREEN && state != ST_PED_BLINK) begin
            ack_nx = 1'b1;
        end

        if (state == ST_UNUSED) begin
            state_nx = ST_ALL_RED_2;
            cd_nx    = TA_C;
            blink_nx = 1'b0;
        end else if (tick && maint_s2) begin
            // Maintenance wins over any expiry happening on the same tick.
            if (state == ST_MAINT_BLINK) begin
                blink_nx = ~blink_r;
            end else begin
                state_nx = ST_MAINT_BLINK;
                cd_nx    = 8'd0;
                blink_nx = 1'b1;
            end
        end else if (tick && state == ST_MAINT_BLINK) begin
            state_nx = ST_ALL_RED_2;
            cd_nx    = TA_C;
            blink_nx = 1'b0;
        end else if (tick && cd <= 8'd1) begin
            // An edge arriving on the expiry tick still counts as a pending request.
            if (state == ST_CAR_GREEN && !(ack || ped_edge)) begin
                cd_nx = TG_C;
            end else begin
                state_nx = next_phase(state);
                cd_nx    = phase_ticks(state_nx);
                blink_nx = (state_nx == ST_PED_BLINK);
                if (state_nx == ST_PED_GREEN) begin
                    ack_nx = 1'b0;
                end
            end
        end else begin
            if (tick) begin
                cd_nx = cd - 8'd1;
                if (state == ST_PED_BLINK) begin
                    blink_nx = ~blink_r;
                end
            end
            if (ped_edge && state == ST_CAR_GREEN && cd > SG_C) begin
                cd_nx = SG_C;
            end
        end
    end

endmodule
